// File: rtl/present80_key_schedule.sv
// PRESENT-80 key schedule: holds K1 after a master-key load and steps to K32 on io_next.
// Optional duplicated state with a sticky mismatch flag: define KEYSCHED_DUP_CHECK_EN.
//
// state  | meaning
// IDLE   | after reset, no key loaded, io_next ignored
// ACTIVE | round key K(round) presented, round = 1..32
// DONE   | schedule exhausted, last key held, io_next ignored
module present80_key_schedule (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_load,
    input  logic [79:0] io_key_in,
    input  logic        io_next,
    output logic [63:0] io_round_key,
    output logic [5:0]  io_round,
    output logic        io_valid,
    output logic        io_last,
    output logic        io_fault
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        state_t      st;
        logic [5:0]  rnd;
        logic [79:0] key;
    } ks_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Rotate left by 61 is the same as rotate right by 19.
    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ c;
        return t;
    endfunction

    function automatic ks_t next_ks(input ks_t cur, input logic load, input logic nxt,
                                    input logic [79:0] key_in);
        ks_t n;
        n = cur;
        if (load) begin
            n.st  = ACTIVE;
            n.rnd = 6'd1;
            n.key = key_in;
        end else if (nxt && (cur.st == ACTIVE)) begin
            if (cur.rnd == 6'd32) begin
                n.st  = DONE;
                n.rnd = 6'd0;
            end else begin
                n.key = key_update(cur.key, cur.rnd[4:0]);
                n.rnd = cur.rnd + 6'd1;
            end
        end
        return n;
    endfunction

    state_t      state;
    logic [5:0]  round;
    logic [79:0] key_reg;
    ks_t         prim_nxt;

    always_comb begin
        prim_nxt = next_ks({state, round, key_reg}, io_load, io_next, io_key_in);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            round   <= 6'd0;
            key_reg <= 80'd0;
        end else begin
            state   <= prim_nxt.st;
            round   <= prim_nxt.rnd;
            key_reg <= prim_nxt.key;
        end
    end

    assign io_round_key = key_reg[79:16];
    assign io_round     = round;
    assign io_valid     = (state == ACTIVE);
    assign io_last      = (state == ACTIVE) && (round == 6'd32);

`ifdef KEYSCHED_DUP_CHECK_EN
    // Shadow copy with its own next-state logic; it never drives the outputs.
    state_t      sh_state;
    logic [5:0]  sh_round;
    logic [79:0] sh_key;
    ks_t         sh_nxt;
    logic        fault_q;

    always_comb begin
        sh_nxt = next_ks({sh_state, sh_round, sh_key}, io_load, io_next, io_key_in);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sh_state <= IDLE;
            sh_round <= 6'd0;
            sh_key   <= 80'd0;
        end else begin
            sh_state <= sh_nxt.st;
            sh_round <= sh_nxt.rnd;
            sh_key   <= sh_nxt.key;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || io_load) begin
            fault_q <= 1'b0;
        end else if ({sh_state, sh_round, sh_key} != {state, round, key_reg}) begin
            fault_q <= 1'b1;
        end
    end

    assign io_fault = fault_q;
`else
    assign io_fault = 1'b0;
`endif

endmodule

// File: tb/tb_present80_key_schedule.sv
// Scoreboard bench for present80_key_schedule: a driver pushes expected outputs per cycle,
// a monitor pops and compares after every rising edge; round keys come from a bit-level model.
module tb_present80_key_schedule;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_load;
    logic [79:0] io_key_in;
    logic        io_next;
    logic [63:0] io_round_key;
    logic [5:0]  io_round;
    logic        io_valid;
    logic        io_last;
    logic        io_fault;

    always #5 clock = ~clock;

    present80_key_schedule dut (
        .clock        (clock),
        .reset        (reset),
        .io_load      (io_load),
        .io_key_in    (io_key_in),
        .io_next      (io_next),
        .io_round_key (io_round_key),
        .io_round     (io_round),
        .io_valid     (io_valid),
        .io_last      (io_last),
        .io_fault     (io_fault)
    );

    typedef struct {
        logic [63:0] rk;
        logic [5:0]  rnd;
        logic        valid;
        logic        last;
        logic        fault;
        logic        chk_rk;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [3:0]  sbox_tbl [16];
    logic [79:0] m_keys [1:32];
    logic [63:0] obs_keys [1:32];
    int          m_state;       // 0 idle, 1 active, 2 done
    int          m_round;
    logic [63:0] m_rk;
    logic        m_fault;
    logic        m_rk_x;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] ex);
        n_checks++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, ex, $time);
        end
    endtask

    // Whole schedule from the textbook rules, working bit by bit.
    function automatic void build_sched(input logic [79:0] mk);
        logic [79:0] k;
        logic [79:0] t;
        logic [4:0]  c;
        k = mk;
        m_keys[1] = k;
        for (int r = 1; r <= 31; r++) begin
            for (int i = 0; i < 80; i++) t[(i + 61) % 80] = k[i];
            t[79:76] = sbox_tbl[t[79:76]];
            c = 5'(r);
            t[19:15] = t[19:15] ^ c;
            k = t;
            m_keys[r + 1] = k;
        end
    endfunction

    function automatic logic [63:0] present_enc(input logic [63:0] pt);
        logic [63:0] s;
        logic [63:0] p;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ obs_keys[r];
            for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbox_tbl[s[n*4 +: 4]];
            p = '0;
            for (int j = 0; j < 63; j++) p[(j * 16) % 63] = s[j];
            p[63] = s[63];
            s = p;
        end
        return s ^ obs_keys[32];
    endfunction

    function automatic logic [79:0] rand_key();
        logic [79:0] k;
        k[31:0]  = $urandom();
        k[63:32] = $urandom();
        k[79:64] = 16'($urandom());
        return k;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.rk     = m_rk;
        e.rnd    = 6'(m_round);
        e.valid  = (m_state == 1);
        e.last   = (m_state == 1) && (m_round == 32);
        e.fault  = m_fault;
        e.chk_rk = !m_rk_x;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic ld, input logic nx, input logic [79:0] k);
        @(negedge clock);
        reset     = rst;
        io_load   = ld;
        io_next   = nx;
        io_key_in = k;
        if (rst) begin
            m_state = 0; m_round = 0; m_rk = '0; m_fault = 1'b0; m_rk_x = 1'b0;
        end else if (ld) begin
            build_sched(k);
            m_state = 1; m_round = 1; m_rk = m_keys[1][79:16]; m_fault = 1'b0; m_rk_x = 1'b0;
        end else if (nx && (m_state == 1)) begin
            if (m_round == 32) begin
                m_state = 2;
                m_round = 0;
            end else begin
                m_round++;
                m_rk = m_keys[m_round][79:16];
            end
        end
        push_exp();
    endtask

    // Corrupt bit 40 of the primary key for one cycle while the schedule sits still.
    task automatic fault_inject();
        @(negedge clock);
        reset   = 1'b0;
        io_load = 1'b0;
        io_next = 1'b0;
        force dut.key_reg = m_keys[m_round] ^ (80'd1 << 40);
`ifdef KEYSCHED_DUP_CHECK_EN
        m_fault = 1'b1;
`endif
        m_rk_x = 1'b1;
        push_exp();
        @(negedge clock);
        release dut.key_reg;
        push_exp();
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (io_valid && (io_round >= 6'd1) && (io_round <= 6'd32)) obs_keys[io_round] = io_round_key;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_rk) chk("round_key", 80'(io_round_key), 80'(e.rk));
            chk("round", 80'(io_round), 80'(e.rnd));
            chk("valid", 80'(io_valid), 80'(e.valid));
            chk("last",  80'(io_last),  80'(e.last));
            chk("fault", 80'(io_fault), 80'(e.fault));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] k;
        int          gaps;
        sbox_tbl = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        for (int i = 1; i <= 32; i++) obs_keys[i] = '0;
        reset = 1'b1; io_load = 1'b0; io_next = 1'b0; io_key_in = '0;
        m_state = 0; m_round = 0; m_rk = '0; m_fault = 1'b0; m_rk_x = 1'b0;

        // Reset, then io_next in IDLE must do nothing.
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        repeat (3) step(0, 0, 1, '0);

        // Zero key: full schedule with back-to-back io_next.
        step(0, 1, 0, 80'd0);
        repeat (31) step(0, 0, 1, '0);
        step(0, 0, 1, '0);
        chk("k1_zero", 80'(obs_keys[1]), 80'(64'h0000000000000000));
        chk("k2_zero", 80'(obs_keys[2]), 80'(64'hC000000000000000));
        chk("k3_zero", 80'(obs_keys[3]), 80'(64'h5000180000000001));
        chk("cipher_zero", 80'(present_enc(64'd0)), 80'(64'h5579C1387B228445));
        repeat (2) step(0, 0, 1, '0);   // DONE ignores io_next, key held

        // Random key with gaps, then load+next together at round 10 with all-ones key.
        step(0, 1, 0, rand_key());
        while (m_round < 10) step(0, 0, ($urandom_range(0, 3) != 0), '0);
        step(0, 1, 1, {80{1'b1}});
        repeat (5) step(0, 0, 1, '0);

        // Reset at round 17 together with io_next, then io_next ignored.
        step(0, 1, 0, rand_key());
        repeat (16) step(0, 0, 1, '0);
        step(1, 0, 1, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, '0);

        // Fault injection at round 5, then recovery by io_load.
        step(0, 1, 0, rand_key());
        repeat (4) step(0, 0, 1, '0);
        fault_inject();
        repeat (3) step(0, 0, ($urandom_range(0, 1) == 1), '0);
        step(0, 1, 0, rand_key());
        repeat (3) step(0, 0, 1, '0);

        // Random loads with random next density, including runs past DONE.
        for (int t = 0; t < 4; t++) begin
            k = rand_key();
            step(0, 1, 0, k);
            gaps = $urandom_range(25, 40);
            for (int c = 0; c < gaps; c++) step(0, 0, ($urandom_range(0, 4) != 0), '0);
        end

        step(0, 0, 0, '0);
        repeat (3) @(posedge clock);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/present80_key_schedule.md
# present80_key_schedule

Sequential PRESENT-80 key schedule that sits directly upstream of the S-box/key-addition stage and drives its 64-bit round-key input. After a master-key load it holds round key K1, then advances to K2…K32 on each `io_next` strobe using the standard rotate / S-box / counter-XOR update. An optional duplicated shadow register detects injected faults in the key state, in line with the fault-vulnerability study.

## Interface
Parameters: none. The key width of 80 and the round count of 32 are fixed.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `io_load`  in  1  capture `io_key_in` and restart at round 1.
- `io_key_in`  in  80  master key; bit 79 = MSB.
- `io_next`  in  1  advance to the next round key.
- `io_round_key`  out  64  current round key, equal to `key_reg[79:16]`.
- `io_round`  out  6  index i of the round key presented (1..32), 0 when idle.
- `io_valid`  out  1  `io_round_key` is meaningful.
- `io_last`  out  1  K32 is presented.
- `io_fault`  out  1  sticky mismatch flag (see Configuration).

## Operation
- States:
  - IDLE: reset state.
  - ACTIVE: rounds 1..32.
  - DONE.
- Registers:
  - `key_reg[79:0]`
  - `round[5:0]`
  - `state`
- `io_load` in any state:
  - `key_reg` ← `io_key_in`; `round` ← 1; state ← ACTIVE.
  - `io_load` has priority over `io_next`.
- `io_next` in ACTIVE with `round` < 32, round counter c = `round`[4:0]:
  - t = `key_reg` rotated left by 61.
  - t[79:76] = S(t[79:76]).
  - t[19:15] ^= c.
  - `key_reg` ← t; `round` ← `round`+1.
- `io_next` in ACTIVE with `round` == 32:
  - state ← DONE; `round` ← 0.
  - `key_reg` is held, not updated.
- `io_next` in IDLE or DONE: ignored.
- S-box (input 0..F → output): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Outputs:
  - `io_valid` = (state == ACTIVE).
  - `io_last` = ACTIVE && `round` == 32.
  - `io_round_key` always shows `key_reg[79:16]`, including in DONE.
- Reset mid-operation: the next edge returns to IDLE and clears all registers; no partial round completes.

## Timing
- Reset values:
  - `io_round_key` = 0, `io_round` = 0.
  - `io_valid` = 0, `io_last` = 0, `io_fault` = 0.
  - State = IDLE.
- All outputs are registered or decoded from registers only. There are no combinational paths from inputs to outputs.
- Load latency: `io_load` sampled at edge n → K1 visible and `io_valid`=1 after edge n.
- Advance latency: `io_next` sampled at edge n → K(i+1) visible after edge n. One round key per cycle at most; back-to-back `io_next` is allowed.
- From load to K32 takes 31 `io_next` cycles. The 32nd `io_next` deasserts `io_valid` and `io_last` on the following edge.
- Round counter XOR uses values 1..31 only; `round` never wraps past 32.

## Configuration
- `KEYSCHED_DUP_CHECK_EN` defined:
  - A shadow `key_reg`/`round`/`state` copy is updated by identical, separately instantiated logic.
  - Every cycle the two copies are compared.
  - Any mismatch sets `io_fault` on the next edge.
  - `io_fault` is sticky; it is cleared only by `reset` or `io_load`.
  - The primary copy always drives the outputs.
- Macro undefined: no shadow logic; `io_fault` is tied to 0.

## Test plan
- Reset → all outputs 0. Then `io_next` for 3 cycles → outputs unchanged, state IDLE.
- Load key 0x0 → `io_round_key`=0x0000000000000000, `io_round`=1, `io_valid`=1. Next → 0xC000000000000000, `io_round`=2. Next → 0x5000180000000001, `io_round`=3.
- Load key 0x0, then 31 consecutive `io_next` → `io_round`=32, `io_last`=1. Check all 32 keys against a software model, and the zero-key/zero-plaintext cipher result 0x5579C1387B228445 through the downstream stage. One more `io_next` → `io_valid`=0, `io_round`=0.
- `io_load` and `io_next` asserted together at round 10 with key 0xFFFF…F → restart: `io_round`=1, `io_round_key`=0xFFFFFFFFFFFFFFFF.
- `reset` asserted at round 17 → next edge IDLE with all outputs 0. A subsequent `io_next` is ignored.
- With `KEYSCHED_DUP_CHECK_EN`: force-flip `key_reg` bit 40 at round 5 → `io_fault`=1 one edge later and it stays 1. Then `io_load` → `io_fault`=0. Without the macro, the same force → `io_fault` stays 0.
